// File: rtl/nx4_pkg.sv
// Shared types and defaults for the multiplexed LED row scheduler.
package nx4_pkg;

  localparam int unsigned DEF_NUM_ROWS   = 8;
  localparam int unsigned DEF_GS_CYCLES  = 4096;
  localparam int unsigned DEF_XLAT_WIDTH = 2;
  localparam int unsigned ROW_W          = 4;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK,
    ST_DISPLAY
  } state_t;

  function automatic row_t next_row(input row_t row, input int unsigned num_rows);
    return (32'(row) == num_rows - 32'd1) ? '0 : row + row_t'(1);
  endfunction

endpackage

// File: rtl/row_scheduler_if.sv
// Shifter handshake and LED driver signals of the row scheduler.
interface row_scheduler_if;
  import nx4_pkg::*;

  logic shift_start;
  row_t shift_row;
  logic shift_done;
  row_t row_sel;
  logic led_blank;
  logic led_xlat;
  logic led_gsclk;
  logic frame_start;
  logic led_xerr;
  row_t xerr_row;
  logic xerr_seen;

  modport master (
    output shift_start, shift_row, row_sel, led_blank, led_xlat, led_gsclk,
           frame_start, xerr_row, xerr_seen,
    input  shift_done, led_xerr
  );

  modport slave (
    input  shift_start, shift_row, row_sel, led_blank, led_xlat, led_gsclk,
           frame_start, xerr_row, xerr_seen,
    output shift_done, led_xerr
  );

endinterface

// File: rtl/gsclk_gen.sv
// Grayscale clock burst: after start, GS_CYCLES high pulses in 2*GS_CYCLES cycles.
module gsclk_gen #(
  parameter int unsigned GS_CYCLES = nx4_pkg::DEF_GS_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic gsclk,
  output logic done
);

  localparam int unsigned     CNT_W = $clog2(GS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GS_CYCLES);

  logic             running;
  logic             gs_q;
  logic [CNT_W-1:0] pulses;

  // done marks the final low phase so the caller leaves on the same edge
  assign done  = running && !gs_q && (pulses == LAST);
  assign gsclk = gs_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      gs_q    <= 1'b0;
      pulses  <= '0;
    end else if (start) begin
      running <= 1'b1;
      gs_q    <= 1'b1;
      pulses  <= '0;
    end else if (done) begin
      running <= 1'b0;
      gs_q    <= 1'b0;
    end else if (running) begin
      gs_q <= !gs_q;
      if (gs_q) pulses <= pulses + CNT_W'(1);
    end
  end

endmodule

// File: rtl/row_scheduler.sv
// LED row scan sequencer: shift / blank / latch / display per row.
// Optional ROW_XERR_LATCH_EN records the row of the first driver error.
module row_scheduler import nx4_pkg::*; #(
  parameter int unsigned NUM_ROWS   = DEF_NUM_ROWS,
  parameter int unsigned GS_CYCLES  = DEF_GS_CYCLES,
  parameter int unsigned XLAT_WIDTH = DEF_XLAT_WIDTH
) (
  input logic             clock,
  input logic             reset_n,
  input logic             enable,
  row_scheduler_if.master bus
);

  localparam logic [3:0] XLAT_LAST = 4'(XLAT_WIDTH - 1);

  state_t     state, state_n;
  logic       done_flag;
  logic [3:0] latch_cnt;
  row_t       row_sel_q;
  row_t       shift_row_q;
  logic       shift_start_q;
  logic       gs_start;
  logic       gs_done;
  logic       gs_clk;

  gsclk_gen #(.GS_CYCLES(GS_CYCLES)) u_gsclk (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (gs_start),
    .gsclk   (gs_clk),
    .done    (gs_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n         = state;
    bus.led_blank   = 1'b1;
    bus.led_xlat    = 1'b0;
    bus.frame_start = 1'b0;
    gs_start        = 1'b0;
    case (state)
      ST_IDLE:    if (enable) state_n = ST_BLANK;
      ST_BLANK:   if (done_flag) state_n = ST_LATCH;
      ST_LATCH: begin
        bus.led_xlat = 1'b1;
        if (latch_cnt == XLAT_LAST) state_n = ST_UNBLANK;
      end
      ST_UNBLANK: begin
        bus.led_blank   = 1'b0;
        bus.frame_start = (row_sel_q == '0);
        gs_start        = 1'b1;
        state_n         = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        bus.led_blank = 1'b0;
        if (gs_done) state_n = enable ? ST_BLANK : ST_IDLE;
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_flag     <= 1'b0;
      latch_cnt     <= '0;
      row_sel_q     <= '0;
      shift_row_q   <= '0;
      shift_start_q <= 1'b0;
    end else begin
      shift_start_q <= 1'b0;
      if (state == ST_IDLE && enable) begin
        shift_start_q <= 1'b1;
        shift_row_q   <= '0;
      end
      if (state == ST_UNBLANK) begin
        shift_start_q <= 1'b1;
        shift_row_q   <= next_row(row_sel_q, NUM_ROWS);
      end
      // a fresh request from IDLE must not be satisfied by a stale completion
      if ((state == ST_BLANK && done_flag) || (state == ST_IDLE && enable))
        done_flag <= 1'b0;
      else if (bus.shift_done)
        done_flag <= 1'b1;
      if (state == ST_LATCH) begin
        latch_cnt <= latch_cnt + 4'd1;
        if (state_n == ST_UNBLANK) row_sel_q <= shift_row_q;
      end else begin
        latch_cnt <= '0;
      end
    end
  end

  assign bus.shift_start = shift_start_q;
  assign bus.shift_row   = shift_row_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.led_gsclk   = gs_clk && (state == ST_DISPLAY);

`ifdef ROW_XERR_LATCH_EN
  logic [1:0] xerr_sync;
  logic       xerr_seen_q;
  row_t       xerr_row_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xerr_sync   <= '1;
      xerr_seen_q <= 1'b0;
      xerr_row_q  <= '0;
    end else begin
      xerr_sync <= {xerr_sync[0], bus.led_xerr};
      if (state == ST_DISPLAY && !xerr_sync[1] && !xerr_seen_q) begin
        xerr_seen_q <= 1'b1;
        xerr_row_q  <= row_sel_q;
      end
    end
  end

  assign bus.xerr_seen = xerr_seen_q;
  assign bus.xerr_row  = xerr_row_q;
`else
  logic unused_xerr;
  assign unused_xerr   = bus.led_xerr;
  assign bus.xerr_seen = 1'b0;
  assign bus.xerr_row  = '0;
`endif

endmodule

// File: tb/tb_row_scheduler.sv
// Scoreboard bench for row_scheduler: expected shifts/rows queued, monitor compares.
module tb_row_scheduler;
  import nx4_pkg::*;

  localparam int NR = 8;
  localparam int GS = 256;
  localparam int XW = 2;

  typedef struct {
    int row;
    int frame;
    int xlat;
    int pulses;
  } row_rec_t;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic enable   = 1'b0;
  logic withhold = 1'b0;

  int checks = 0;
  int errors = 0;

  int       exp_shift[$];
  row_rec_t exp_rows[$];

  // monitor state
  int       in_disp = 0, pulses = 0, rows_done = 0, frames = 0, gs_leak = 0;
  int       cur_row = 0, cur_frame = 0, cur_xlat = 0, xlat_len = 0;
  int       prev_gs = 0, prev_xlat = 0;
  row_rec_t mon_e;

  row_scheduler_if bus ();

  row_scheduler #(.NUM_ROWS(NR), .GS_CYCLES(GS), .XLAT_WIDTH(XW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_blank"},    int'(bus.led_blank),   1);
    check({tag, "_xlat"},     int'(bus.led_xlat),    0);
    check({tag, "_gsclk"},    int'(bus.led_gsclk),   0);
    check({tag, "_sstart"},   int'(bus.shift_start), 0);
    check({tag, "_frame"},    int'(bus.frame_start), 0);
    check({tag, "_row_sel"},  int'(bus.row_sel),     0);
    check({tag, "_shiftrow"}, int'(bus.shift_row),   0);
    check({tag, "_xseen"},    int'(bus.xerr_seen),   0);
    check({tag, "_xrow"},     int'(bus.xerr_row),    0);
  endtask

  task automatic wait_rows(input int n, input int budget);
    int c = 0;
    while (rows_done < n && c < budget) begin @(posedge clock); c++; end
    check("rows_reached", int'(rows_done >= n), 1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int c = 0;
    while (!(in_disp != 0 && pulses >= n) && c < budget) begin @(posedge clock); c++; end
    check("pulses_reached", int'(in_disp != 0 && pulses >= n), 1);
  endtask

  task automatic xerr_on_row(input int r);
    int c = 0;
    while (!(in_disp != 0 && cur_row == r && pulses >= 10) && c < 20000) begin
      @(posedge clock); c++;
    end
    #1 bus.led_xerr = 1'b0;
    repeat (4) @(posedge clock);
    #1 bus.led_xerr = 1'b1;
  endtask

  // shifter model: shift_done five cycles after shift_start unless withheld
  initial begin : shifter
    int pend, cnt;
    pend = 0;
    cnt  = 0;
    bus.shift_done = 1'b0;
    forever begin
      @(posedge clock);
      #1 bus.shift_done = 1'b0;
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend != 0 && !withhold) begin
          if (cnt == 0) begin bus.shift_done = 1'b1; pend = 0; end
          else cnt--;
        end
        if (bus.shift_start) begin pend = 1; cnt = 4; end
      end
    end
  end

  initial begin : xerr_stim
    bus.led_xerr = 1'b1;
    xerr_on_row(3);
    xerr_on_row(5);
  end

  always @(negedge clock) begin : monitor
    if (!reset_n) begin
      in_disp   = 0;
      xlat_len  = 0;
      prev_xlat = 0;
      prev_gs   = 0;
    end else begin
      if (bus.shift_start) begin
        if (exp_shift.size() == 0) check("shift_unexpected", int'(bus.shift_row), -1);
        else check("shift_row", int'(bus.shift_row), exp_shift.pop_front());
      end
      if (bus.led_xlat) xlat_len = (prev_xlat != 0) ? xlat_len + 1 : 1;
      if (bus.frame_start) frames++;
      if (bus.led_gsclk && bus.led_blank) gs_leak++;
      if (in_disp == 0 && !bus.led_blank) begin
        in_disp   = 1;
        cur_row   = int'(bus.row_sel);
        cur_frame = int'(bus.frame_start);
        cur_xlat  = xlat_len;
        pulses    = 0;
      end else if (in_disp != 0 && bus.led_blank) begin
        in_disp = 0;
        rows_done++;
        if (exp_rows.size() == 0) check("row_unexpected", cur_row, -1);
        else begin
          mon_e = exp_rows.pop_front();
          check("row_sel",     cur_row,   mon_e.row);
          check("frame_start", cur_frame, mon_e.frame);
          check("xlat_width",  cur_xlat,  mon_e.xlat);
          check("gs_pulses",   pulses,    mon_e.pulses);
        end
      end
      if (in_disp != 0 && bus.led_gsclk && prev_gs == 0) pulses++;
      prev_gs   = int'(bus.led_gsclk);
      prev_xlat = int'(bus.led_xlat);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bad, base;
    repeat (3) @(posedge clock);
    #1 check_reset("reset");

    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("idle_blank",    int'(bus.led_blank),   1);
    check("idle_no_shift", int'(bus.shift_start), 0);

    // nine rows with wrap, enable dropped at pulse 100 of the last row
    for (int i = 0; i < 10; i++) exp_shift.push_back(i % NR);
    for (int i = 0; i < 9; i++) exp_rows.push_back('{i % NR, int'((i % NR) == 0), XW, GS});
    enable = 1'b1;
    wait_rows(8, 8 * 700);
    wait_pulses(100, 700);
    enable = 1'b0;
    wait_rows(9, 700);
    repeat (20) @(posedge clock);
    #1;
    check("end_idle_blank", int'(bus.led_blank), 1);
    check("end_idle_gsclk", int'(bus.led_gsclk), 0);
    check("end_row_sel",    int'(bus.row_sel),   0);
    check("frame_count",    frames,              2);
    check("shift_q_empty",  exp_shift.size(),    0);
    check("row_q_empty",    exp_rows.size(),     0);
    check("gsclk_leak",     gs_leak,             0);
`ifdef ROW_XERR_LATCH_EN
    check("xerr_seen", int'(bus.xerr_seen), 1);
    check("xerr_row",  int'(bus.xerr_row),  3);
`else
    check("xerr_seen", int'(bus.xerr_seen), 0);
    check("xerr_row",  int'(bus.xerr_row),  0);
`endif

    // withheld shift_done keeps the drivers blanked
    exp_shift.push_back(0);
    withhold = 1'b1;
    enable   = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (!bus.led_blank || bus.led_gsclk || bus.led_xlat) bad++;
    end
    check("withhold_blank", bad, 0);
    withhold = 1'b0;
    bad = 0;
    @(negedge clock);
    while (!bus.led_xlat && bad < 50) begin @(negedge clock); bad++; end
    check("latch_reached", int'(bus.led_xlat), 1);

    // asynchronous reset in the first LATCH cycle
    reset_n = 1'b0;
    #1 check_reset("latch_reset");
    enable = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.led_xlat || bus.shift_start || !bus.led_blank) bad++;
    end
    check("post_reset_quiet", bad,              0);
    check("shift_q_drained",  exp_shift.size(), 0);

    // recovery: one full row after reset
    exp_shift.push_back(0);
    exp_shift.push_back(1);
    exp_rows.push_back('{0, 1, XW, GS});
    base = rows_done;
    @(negedge clock) enable = 1'b1;
    #1 check("no_early_shift", int'(bus.shift_start), 0);
    wait_pulses(1, 100);
    enable = 1'b0;
    wait_rows(base + 1, 700);
    repeat (20) @(posedge clock);
    #1;
    check("final_blank",     int'(bus.led_blank), 1);
    check("final_shift_q",   exp_shift.size(),    0);
    check("final_row_q",     exp_rows.size(),     0);
    check("final_frames",    frames,              3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
